// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding and load-use hazard detection.
// Tracks in-flight destination tags in a DEPTH-entry shift pipeline and
// selects the youngest matching result for each source operand, stalling
// issue while that result is a load whose data is not yet valid.
// Optional macro FWD_STATS_EN builds a saturating stall-cycle counter;
// when undefined, stall_count is tied to zero.
module fwd_hazard_unit #(
   parameter int WIDTH      = 16,
   parameter int AW         = 3,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   iss_valid,
   input  logic [AW-1:0]          iss_rs_a,
   input  logic [AW-1:0]          iss_rs_b,
   input  logic [AW-1:0]          iss_rd,
   input  logic                   iss_we,
   input  logic                   iss_load,
   input  logic                   flush,
   input  logic [WIDTH-1:0]       rf_a,
   input  logic [WIDTH-1:0]       rf_b,
   input  logic [DEPTH*WIDTH-1:0] res_data,
   output logic [WIDTH-1:0]       fwd_a,
   output logic [WIDTH-1:0]       fwd_b,
   output logic                   hit_a,
   output logic                   hit_b,
   output logic                   stall,
   output logic [15:0]            stall_count
);

   // Tag pipeline, index 0 holds stage 1 (EX output), index DEPTH-1 is WB.
   logic [DEPTH-1:0]         vld_q, vld_d;
   logic [DEPTH-1:0]         we_q, we_d;
   logic [DEPTH-1:0]         ld_q, ld_d;
   logic [DEPTH-1:0][AW-1:0] rd_q, rd_d;

   logic [1:0][AW-1:0]    rs;
   logic [1:0][WIDTH-1:0] rf;
   logic [1:0][WIDTH-1:0] fwd;
   logic [1:0]            hit;
   logic [1:0]            found;
   logic [1:0]            not_ready;

   assign rs[0] = iss_rs_a;
   assign rs[1] = iss_rs_b;
   assign rf[0] = rf_a;
   assign rf[1] = rf_b;

   // Per-operand priority match: first (youngest) matching stage wins.
   always_comb begin
      fwd       = '0;
      hit       = '0;
      found     = '0;
      not_ready = '0;
      for (int unsigned op = 0; op < 2; op++) begin
         fwd[op] = (rs[op] == '0) ? '0 : rf[op];
         for (int unsigned k = 0; k < DEPTH; k++) begin
            if (!found[op] && vld_q[k] && we_q[k] &&
                rd_q[k] == rs[op] && rs[op] != '0) begin
               found[op] = 1'b1;
               if (!ld_q[k] || (k + 1) >= LOAD_STAGE) begin
                  hit[op] = 1'b1;
                  fwd[op] = res_data[k*WIDTH +: WIDTH];
               end else begin
                  not_ready[op] = 1'b1;
               end
            end
         end
      end
   end

   assign fwd_a = fwd[0];
   assign fwd_b = fwd[1];
   assign hit_a = hit[0];
   assign hit_b = hit[1];
   assign stall = iss_valid & (not_ready[0] | not_ready[1]);

   // Next tag state: new entry (or bubble) into stage 1, others shift down.
   always_comb begin
      vld_d    = '0;
      we_d     = '0;
      ld_d     = '0;
      rd_d     = '0;
      vld_d[0] = iss_valid & ~stall & ~flush;
      we_d[0]  = iss_we;
      ld_d[0]  = iss_load;
      rd_d[0]  = iss_rd;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         vld_d[k] = vld_q[k-1];
         we_d[k]  = we_q[k-1];
         ld_d[k]  = ld_q[k-1];
         rd_d[k]  = rd_q[k-1];
      end
   end

   // Tag pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         we_q  <= '0;
         ld_q  <= '0;
         rd_q  <= '0;
      end else begin
         vld_q <= vld_d;
         we_q  <= we_d;
         ld_q  <= ld_d;
         rd_q  <= rd_d;
      end
   end

`ifdef FWD_STATS_EN
   logic [15:0] stall_count_q, stall_count_d;

   // Saturating count of stalled cycles.
   always_comb begin
      stall_count_d = stall_count_q;
      if (stall && stall_count_q != '1) begin
         stall_count_d = stall_count_q + 16'd1;
      end
   end

   // Stall counter register, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_count_q <= '0;
      end else begin
         stall_count_q <= stall_count_d;
      end
   end

   assign stall_count = stall_count_q;
`else
   assign stall_count = '0;
`endif

endmodule
